conv_window_buf: RTL and testbench

- Parametrised sliding-window buffer for the conv datapath; successor to the fixed 3x3 8-bit circular image register.
- Accepts one column of K_H pixels per handshake and keeps the most recent K_W columns per image row.
- Emits full K_H x K_W windows with a valid/ready handshake, stride control, per-row fill tracking and row-end flagging.
- Sits between the line-buffer read side and the MAC array.

---
 rtl/conv_window_buf.sv | 151 +++++++++++++++
 tb/tb_conv_window_buf.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buf.sv
// rtl/conv_window_buf.sv - K_H x K_W sliding-window buffer with stride, fill tracking and row-end flag
// Define CONV_WINDOW_ZPAD_EN to add (K_W-1)/2 zero columns at both ends of every row.
module conv_window_buf #(
  parameter int DW     = 8,
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IMG_W  = 32,
  parameter int STRIDE = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [0:K_H-1][DW-1:0]          in_col,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [0:K_H-1][0:K_W-1][DW-1:0] win_data,
  output logic [$clog2(IMG_W+K_W)-1:0]    win_col,
  output logic                            row_last
);

`ifdef CONV_WINDOW_ZPAD_EN
  localparam int PAD = (K_W - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int IMG_W_P = IMG_W + 2 * PAD;
  localparam int CW      = $clog2(IMG_W + K_W);
  localparam int FW      = $clog2(K_W + 1);
  localparam int SW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;

`ifdef CONV_WINDOW_ZPAD_EN
  typedef enum logic [1:0] {FILL, RUN, PAD_TAIL} state_t;
`else
  typedef enum logic [1:0] {FILL, RUN} state_t;
`endif

  state_t                          state, state_nxt;
  logic [0:K_H-1][0:K_W-1][DW-1:0] win_reg, win_shift;
  logic [CW-1:0]                   col_cnt, col_after, emit_col;
  logic [FW-1:0]                   fill, fill_after;
  logic [SW-1:0]                   stride_cnt;
  logic                            stall, shift, pad_shift, row_end, emit, emit_last;

  assign stall = win_valid && !win_ready;

`ifdef CONV_WINDOW_ZPAD_EN
  logic last_real;
  assign in_ready  = rst_n && !stall && (state != PAD_TAIL);
  assign pad_shift = !stall && (state == PAD_TAIL);
  assign last_real = shift && (col_after == CW'(IMG_W + PAD));
`else
  assign in_ready  = rst_n && !stall;
  assign pad_shift = 1'b0;
`endif

  assign shift      = (in_valid && in_ready) || pad_shift;
  assign col_after  = col_cnt + CW'(1);
  assign fill_after = (fill == FW'(K_W)) ? fill : fill + FW'(1);
  assign row_end    = shift && (col_after == CW'(IMG_W_P));
  assign emit       = shift && (fill_after == FW'(K_W)) && (stride_cnt == '0);
  assign emit_col   = col_after - CW'(K_W);
  assign emit_last  = (32'(emit_col) + 32'(STRIDE)) > 32'(IMG_W_P - K_W);

  // Column 0 is always the newest; tail padding shifts in zeros instead of in_col.
  always_comb begin
    win_shift = win_reg;
    for (int r = 0; r < K_H; r++) begin
      for (int j = K_W - 1; j >= 1; j--) begin
        win_shift[r][j] = win_reg[r][j-1];
      end
      win_shift[r][0] = pad_shift ? '0 : in_col[r];
    end
  end

  always_comb begin
    state_nxt = state;
    if (shift) begin
      if (row_end) begin
        state_nxt = FILL;
`ifdef CONV_WINDOW_ZPAD_EN
      end else if (last_real || state == PAD_TAIL) begin
        state_nxt = PAD_TAIL;
`endif
      end else if (fill_after == FW'(K_W)) begin
        state_nxt = RUN;
      end else begin
        state_nxt = FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else if (clear) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Window registers survive a row end; fill gates emission so stale columns never escape.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_reg    <= '0;
      col_cnt    <= CW'(PAD);
      fill       <= FW'(PAD);
      stride_cnt <= '0;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_col    <= '0;
      row_last   <= 1'b0;
    end else if (clear) begin
      win_reg    <= '0;
      col_cnt    <= CW'(PAD);
      fill       <= FW'(PAD);
      stride_cnt <= '0;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_col    <= '0;
      row_last   <= 1'b0;
    end else begin
      if (shift) begin
        if (row_end) begin
          col_cnt    <= CW'(PAD);
          fill       <= FW'(PAD);
          stride_cnt <= '0;
          win_reg    <= (PAD > 0) ? '0 : win_shift;
        end else begin
          col_cnt <= col_after;
          fill    <= fill_after;
          win_reg <= win_shift;
          if (fill_after == FW'(K_W)) begin
            stride_cnt <= (stride_cnt == SW'(STRIDE - 1)) ? '0 : stride_cnt + SW'(1);
          end
        end
      end
      if (emit) begin
        win_valid <= 1'b1;
        win_data  <= win_shift;
        win_col   <= emit_col;
        row_last  <= emit_last;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buf.sv
// tb/tb_conv_window_buf.sv - bench for conv_window_buf: STRIDE=1 and STRIDE=2 instances against a window-position model
// Honours CONV_WINDOW_ZPAD_EN in the same way as the design.
module tb_conv_window_buf;
  localparam int DW = 8, K_H = 3, K_W = 3, IMG_W = 8;
`ifdef CONV_WINDOW_ZPAD_EN
  localparam int PAD = (K_W - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int IMG_W_P = IMG_W + 2 * PAD;
  localparam int CW = $clog2(IMG_W + K_W);

  logic clk = 1'b0;
  logic rst_n, clear;
  logic iv[2], rdy[2], wv[2], wr[2], wl[2];
  logic [0:K_H-1][DW-1:0] in_col;
  logic [0:K_H-1][0:K_W-1][DW-1:0] wd[2];
  logic [CW-1:0] wc[2];

  int checks = 0, errors = 0;

  // Model: columns of the current row in padded coordinates, pending window, tail flag.
  logic [0:K_H-1][DW-1:0] hist[2][64];
  logic [0:K_H-1][0:K_W-1][DW-1:0] m_data[2];
  bit m_valid[2], m_last[2], m_tail[2];
  int m_col[2], m_cnt[2];

  int log_n[2], log_col[2][64], log_last[2][64], log_d00[2][64], log_d02[2][64], log_d20[2][64];

  always #5 clk = ~clk;

  conv_window_buf #(.DW(DW), .K_H(K_H), .K_W(K_W), .IMG_W(IMG_W), .STRIDE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[0]), .in_ready(rdy[0]), .in_col(in_col),
    .win_valid(wv[0]), .win_ready(wr[0]), .win_data(wd[0]), .win_col(wc[0]), .row_last(wl[0]));

  conv_window_buf #(.DW(DW), .K_H(K_H), .K_W(K_W), .IMG_W(IMG_W), .STRIDE(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[1]), .in_ready(rdy[1]), .in_col(in_col),
    .win_valid(wv[1]), .win_ready(wr[1]), .win_data(wd[1]), .win_col(wc[1]), .row_last(wl[1]));

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int strd(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic row_start(input int d);
    m_cnt[d] = PAD;
    m_tail[d] = 1'b0;
    for (int p = 0; p < PAD; p++) hist[d][p] = '0;
  endtask

  task automatic model_reset(input int d);
    m_valid[d] = 1'b0;
    m_last[d] = 1'b0;
    m_col[d] = 0;
    m_data[d] = '0;
    row_start(d);
  endtask

  task automatic model_step(input int d, input bit rdy_e);
    bit sh, emit;
    if (clear) begin
      model_reset(d);
    end else begin
      sh = m_tail[d] ? !(m_valid[d] && !wr[d]) : (iv[d] && rdy_e);
      emit = 1'b0;
      if (sh) begin
        hist[d][m_cnt[d]] = m_tail[d] ? '0 : in_col;
        m_cnt[d]++;
        if (m_cnt[d] >= K_W && ((m_cnt[d] - K_W) % strd(d)) == 0) begin
          emit = 1'b1;
          m_col[d] = m_cnt[d] - K_W;
          m_last[d] = (m_col[d] + strd(d)) > (IMG_W_P - K_W);
          for (int r = 0; r < K_H; r++)
            for (int j = 0; j < K_W; j++)
              m_data[d][r][j] = hist[d][m_cnt[d] - 1 - j][r];
        end
        if (m_cnt[d] == IMG_W_P) row_start(d);
        else if (m_cnt[d] == IMG_W + PAD) m_tail[d] = 1'b1;
      end
      if (emit) m_valid[d] = 1'b1;
      else if (wr[d]) m_valid[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) model_reset(d);
    forever begin
      @(negedge clk);
      if (!rst_n) for (int d = 0; d < 2; d++) model_reset(d);
      for (int d = 0; d < 2; d++) begin
        bit exp_rdy;
        exp_rdy = rst_n && !(m_valid[d] && !wr[d]) && !m_tail[d];
        chk("in_ready", d, rdy[d], exp_rdy);
        chk("win_valid", d, wv[d], m_valid[d]);
        if (m_valid[d] || !rst_n) begin
          chk("win_data", d, wd[d], m_data[d]);
          chk("win_col", d, wc[d], m_col[d]);
          chk("row_last", d, wl[d], m_last[d]);
        end
        if (rst_n && wv[d] && wr[d] && log_n[d] < 64) begin
          log_col[d][log_n[d]]  = wc[d];
          log_last[d][log_n[d]] = wl[d];
          log_d00[d][log_n[d]]  = wd[d][0][0];
          log_d02[d][log_n[d]]  = wd[d][0][K_W-1];
          log_d20[d][log_n[d]]  = wd[d][K_H-1][0];
          log_n[d]++;
        end
        if (rst_n) model_step(d, exp_rdy);
      end
    end
  end

  task automatic clear_log();
    log_n[0] = 0;
    log_n[1] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pixel value for row r is column value + 16*r.
  task automatic send(input int d, input int v);
    int n;
    n = 0;
    for (int r = 0; r < K_H; r++) in_col[r] = DW'(v + 16 * r);
    iv[d] = 1'b1;
    @(negedge clk);
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d col %0d", d, v);
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    iv[0] = 1'b0; iv[1] = 1'b0;
    wr[0] = 1'b1; wr[1] = 1'b1;
    in_col = '0;
    clear_log();
    #2;
    chk("rst_valid", 0, wv[0], 0);
    chk("rst_ready", 0, rdy[0], 0);
    chk("rst_col", 0, wc[0], 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("rel_ready", 0, rdy[0], 1);

`ifdef CONV_WINDOW_ZPAD_EN
    for (int c = 0; c < 8; c++) begin
      send(0, c);
      if (c == 7) chk("zp_tail_rdy", 0, rdy[0], 0);
    end
    @(posedge clk); #1;
    chk("zp_tail_done", 0, rdy[0], 1);
    idle(3);
    chk("zp_n", 0, log_n[0], 8);
    for (int i = 0; i < 8; i++) begin
      chk("zp_col", 0, log_col[0][i], i);
      chk("zp_last", 0, log_last[0][i], (i == 7));
    end
    chk("zp_first_d02", 0, log_d02[0][0], 0);
    chk("zp_first_d00", 0, log_d00[0][0], 1);
    chk("zp_last_d00", 0, log_d00[0][7], 0);
    chk("zp_last_d02", 0, log_d02[0][7], 6);
`else
    clear_log();
    for (int c = 0; c < 8; c++) begin
      send(0, c);
      if (c == 1) chk("lat_c1", 0, wv[0], 0);
      if (c == 2) chk("lat_c2", 0, wv[0], 1);
    end
    idle(3);
    chk("s1_n", 0, log_n[0], 6);
    for (int i = 0; i < 6; i++) begin
      chk("s1_col", 0, log_col[0][i], i);
      chk("s1_last", 0, log_last[0][i], (i == 5));
    end
    chk("s1_d00", 0, log_d00[0][0], 2);
    chk("s1_d02", 0, log_d02[0][0], 0);
    chk("s1_d20", 0, log_d20[0][0], 34);

    clear_log();
    for (int c = 0; c < 8; c++) begin
      send(1, c);
      if (c == 7) chk("s2_c7_noemit", 1, wv[1], 0);
    end
    idle(3);
    chk("s2_n", 1, log_n[1], 3);
    for (int i = 0; i < 3; i++) begin
      chk("s2_col", 1, log_col[1][i], 2 * i);
      chk("s2_last", 1, log_last[1][i], (i == 2));
    end
    send(1, 0);
    send(1, 1);
    chk("s2_row2_fill", 1, wv[1], 0);
    send(1, 2);
    chk("s2_row2_win", 1, wv[1], 1);
    chk("s2_row2_col", 1, wc[1], 0);
    for (int c = 3; c < 8; c++) send(1, c);
    idle(3);

    clear_log();
    send(0, 0); send(0, 1); send(0, 2);
    wr[0] = 1'b0;
    for (int r = 0; r < K_H; r++) in_col[r] = DW'(3 + 16 * r);
    iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rdy", 0, rdy[0], 0);
      chk("stall_col", 0, wc[0], 0);
      chk("stall_d00", 0, wd[0][0][0], 2);
    end
    @(posedge clk); #1;
    wr[0] = 1'b1;
    for (int c = 3; c < 8; c++) send(0, c);
    idle(3);
    chk("stall_n", 0, log_n[0], 6);
    for (int i = 0; i < 6; i++) chk("stall_order", 0, log_col[0][i], i);

    for (int c = 0; c < 5; c++) send(0, c);
    chk("pre_clear_valid", 0, wv[0], 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_valid", 0, wv[0], 0);
    chk("clr_col", 0, wc[0], 0);
    clear_log();
    send(0, 10); send(0, 11); send(0, 12);
    idle(2);
    chk("clr_n", 0, log_n[0], 1);
    chk("clr_win_col", 0, log_col[0][0], 0);
    chk("clr_d00", 0, log_d00[0][0], 12);
    chk("clr_d02", 0, log_d02[0][0], 10);

    send(0, 0); send(0, 1); send(0, 2); send(0, 3);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_valid", d, wv[d], 0);
      chk("arst_col", d, wc[d], 0);
      chk("arst_last", d, wl[d], 0);
      chk("arst_data", d, wd[d], 0);
      chk("arst_ready", d, rdy[d], 0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("arst_rel_ready", 0, rdy[0], 1);
    clear_log();
    for (int c = 0; c < 8; c++) send(0, c);
    idle(3);
    chk("arst_row_n", 0, log_n[0], 6);
    chk("arst_row_col0", 0, log_col[0][0], 0);
    chk("arst_row_d00", 0, log_d00[0][0], 2);
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
